// File: rtl/guvm_mem_arbiter_if.sv
// Bus bundle for guvm_mem_arbiter: instruction port, data port and shared memory channel.
// The arbiter connects through the slave modport; the requesters/memory model use master.
interface guvm_mem_arbiter_if;
   logic        instr_req_i;
   logic [31:0] instr_addr_i;
   logic        instr_gnt_o;
   logic        instr_rvalid_o;

   logic        data_req_i;
   logic        data_we_i;
   logic [3:0]  data_be_i;
   logic [31:0] data_addr_i;
   logic [31:0] data_wdata_i;
   logic        data_gnt_o;
   logic        data_rvalid_o;

   logic [31:0] rdata_o;

   logic        mem_req_o;
   logic        mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_gnt_i;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;

   modport slave (
      input  instr_req_i, instr_addr_i,
      output instr_gnt_o, instr_rvalid_o,
      input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
      output data_gnt_o, data_rvalid_o,
      output rdata_o,
      output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
      input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
   );

   modport master (
      output instr_req_i, instr_addr_i,
      input  instr_gnt_o, instr_rvalid_o,
      output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
      input  data_gnt_o, data_rvalid_o,
      input  rdata_o,
      input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
      output mem_gnt_i, mem_rvalid_i, mem_rdata_i
   );
endinterface

// File: rtl/guvm_mem_arbiter.sv
// Two-requester (instr/data) arbiter onto one in-order memory channel with an ID FIFO for responses.
// Define GUVM_ARB_ROUND_ROBIN_EN for round-robin contention; default is fixed data priority.
module guvm_mem_arbiter #(
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   guvm_mem_arbiter_if.slave bus,
   output logic              err_o
);

   typedef enum logic {ST_OPEN, ST_LOCKED} lock_state_e;
   typedef enum logic {ID_INSTR = 1'b0, ID_DATA = 1'b1} req_id_e;

   localparam logic [2:0] DEPTH    = 3'(MAX_OUTSTANDING);
   localparam logic [1:0] LAST_PTR = 2'(MAX_OUTSTANDING - 1);

   lock_state_e state_q, state_d;
   req_id_e     sel;
   req_id_e     locked_sel_q, locked_sel_d;
   req_id_e     id_fifo_q [4];
   req_id_e     head_id;
   logic [1:0]  wr_ptr_q, rd_ptr_q;
   logic [2:0]  count_q;
   logic        any_req;
   logic        not_full;
   logic        handshake;
   logic        pop;
   logic        spurious;

`ifdef GUVM_ARB_ROUND_ROBIN_EN
   req_id_e     prio_q;
`endif

   function automatic logic [1:0] next_ptr(input logic [1:0] p);
      return (p == LAST_PTR) ? 2'd0 : p + 2'd1;
   endfunction

   assign any_req   = bus.instr_req_i | bus.data_req_i;
   assign not_full  = (count_q < DEPTH);
   assign handshake = bus.mem_req_o & bus.mem_gnt_i;
   assign head_id   = id_fifo_q[rd_ptr_q];
   assign pop       = bus.mem_rvalid_i & (count_q != 3'd0) & !rst_i;
   assign spurious  = bus.mem_rvalid_i & (count_q == 3'd0);

   // A stalled request keeps its selection so the memory never sees fields change mid-request.
   always_comb begin
      if (state_q == ST_LOCKED) begin
         sel = locked_sel_q;
      end else if (bus.instr_req_i && bus.data_req_i) begin
`ifdef GUVM_ARB_ROUND_ROBIN_EN
         sel = prio_q;
`else
         sel = ID_DATA;
`endif
      end else if (bus.data_req_i) begin
         sel = ID_DATA;
      end else begin
         sel = ID_INSTR;
      end
   end

   always_comb begin
      bus.mem_req_o   = any_req & not_full & !rst_i;
      bus.mem_we_o    = 1'b0;
      bus.mem_be_o    = 4'hF;
      bus.mem_addr_o  = bus.instr_addr_i;
      bus.mem_wdata_o = '0;
      if (sel == ID_DATA) begin
         bus.mem_we_o    = bus.data_we_i;
         bus.mem_be_o    = bus.data_be_i;
         bus.mem_addr_o  = bus.data_addr_i;
         bus.mem_wdata_o = bus.data_wdata_i;
      end
   end

   assign bus.instr_gnt_o    = handshake & (sel == ID_INSTR);
   assign bus.data_gnt_o     = handshake & (sel == ID_DATA);
   assign bus.instr_rvalid_o = pop & (head_id == ID_INSTR);
   assign bus.data_rvalid_o  = pop & (head_id == ID_DATA);
   assign bus.rdata_o        = bus.mem_rdata_i;

   always_comb begin
      state_d      = state_q;
      locked_sel_d = locked_sel_q;
      if (handshake) begin
         state_d = ST_OPEN;
      end else if (bus.mem_req_o) begin
         state_d      = ST_LOCKED;
         locked_sel_d = sel;
      end else begin
         state_d = ST_OPEN;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_OPEN;
         locked_sel_q <= ID_INSTR;
      end else begin
         state_q      <= state_d;
         locked_sel_q <= locked_sel_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         err_o    <= 1'b0;
         for (int unsigned i = 0; i < 4; i++) begin
            id_fifo_q[i] <= ID_INSTR;
         end
      end else begin
         if (handshake) begin
            id_fifo_q[wr_ptr_q] <= sel;
            wr_ptr_q            <= next_ptr(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_q <= next_ptr(rd_ptr_q);
         end
         case ({handshake, pop})
            2'b10:   count_q <= count_q + 3'd1;
            2'b01:   count_q <= count_q - 3'd1;
            default: count_q <= count_q;
         endcase
         if (spurious) begin
            err_o <= 1'b1;
         end
      end
   end

`ifdef GUVM_ARB_ROUND_ROBIN_EN
   // The requester that just lost becomes the contention winner for the next handshake.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prio_q <= ID_INSTR;
      end else if (handshake) begin
         prio_q <= (sel == ID_INSTR) ? ID_DATA : ID_INSTR;
      end
   end
`endif

endmodule

// File: tb/tb_guvm_mem_arbiter.sv
// Directed self-checking bench for guvm_mem_arbiter (MAX_OUTSTANDING = 2).
// Contention expectations follow GUVM_ARB_ROUND_ROBIN_EN when it is defined.
module tb_guvm_mem_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic err;
   int   checks = 0;
   int   errors = 0;

   guvm_mem_arbiter_if bus ();

   guvm_mem_arbiter #(.MAX_OUTSTANDING(2)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus),
      .err_o (err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.instr_req_i  = 1'b0;
      bus.instr_addr_i = '0;
      bus.data_req_i   = 1'b0;
      bus.data_we_i    = 1'b0;
      bus.data_be_i    = '0;
      bus.data_addr_i  = '0;
      bus.data_wdata_i = '0;
      bus.mem_gnt_i    = 1'b0;
      bus.mem_rvalid_i = 1'b0;
      bus.mem_rdata_i  = '0;
   endtask

   initial begin
      idle_inputs();
      // Outputs held low during reset even with live requests and a response
      bus.instr_req_i  = 1'b1;
      bus.mem_gnt_i    = 1'b1;
      bus.mem_rvalid_i = 1'b1;
      #1;
      chk("rst_mem_req", bus.mem_req_o, 1'b0);
      chk("rst_instr_gnt", bus.instr_gnt_o, 1'b0);
      chk("rst_instr_rvalid", bus.instr_rvalid_o, 1'b0);
      chk("rst_data_rvalid", bus.data_rvalid_o, 1'b0);
      tick();
      chk("rst_err", err, 1'b0);
      idle_inputs();
      rst = 1'b0;
      tick();

      // Single fetch
      bus.instr_req_i  = 1'b1;
      bus.instr_addr_i = 32'h0000_0100;
      bus.mem_gnt_i    = 1'b1;
      #1;
      chk("fetch_mem_req", bus.mem_req_o, 1'b1);
      chk("fetch_addr", bus.mem_addr_o, 32'h0000_0100);
      chk("fetch_be", bus.mem_be_o, 4'hF);
      chk("fetch_we", bus.mem_we_o, 1'b0);
      chk("fetch_wdata", bus.mem_wdata_o, 32'h0);
      chk("fetch_instr_gnt", bus.instr_gnt_o, 1'b1);
      chk("fetch_data_gnt", bus.data_gnt_o, 1'b0);
      tick();
      idle_inputs();
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i  = 32'h0021_80B3;
      #1;
      chk("fetch_instr_rvalid", bus.instr_rvalid_o, 1'b1);
      chk("fetch_data_rvalid", bus.data_rvalid_o, 1'b0);
      chk("fetch_rdata", bus.rdata_o, 32'h0021_80B3);
      tick();
      bus.mem_rvalid_i = 1'b0;

      // Contention from a fresh reset (round-robin priority back at instr)
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.instr_req_i  = 1'b1;
      bus.instr_addr_i = 32'h0000_0200;
      bus.data_req_i   = 1'b1;
      bus.data_we_i    = 1'b1;
      bus.data_be_i    = 4'hF;
      bus.data_addr_i  = 32'h0000_0010;
      bus.data_wdata_i = 32'hDEAD_BEEF;
      bus.mem_gnt_i    = 1'b1;
      #1;
`ifdef GUVM_ARB_ROUND_ROBIN_EN
      chk("cont1_instr_gnt", bus.instr_gnt_o, 1'b1);
      chk("cont1_data_gnt", bus.data_gnt_o, 1'b0);
      chk("cont1_addr", bus.mem_addr_o, 32'h0000_0200);
`else
      chk("cont1_instr_gnt", bus.instr_gnt_o, 1'b0);
      chk("cont1_data_gnt", bus.data_gnt_o, 1'b1);
      chk("cont1_addr", bus.mem_addr_o, 32'h0000_0010);
      chk("cont1_we", bus.mem_we_o, 1'b1);
      chk("cont1_wdata", bus.mem_wdata_o, 32'hDEAD_BEEF);
`endif
      tick();
      #1;
      chk("cont2_data_gnt", bus.data_gnt_o, 1'b1);
      chk("cont2_instr_gnt", bus.instr_gnt_o, 1'b0);
      tick();
      chk("cont_full_mem_req", bus.mem_req_o, 1'b0);
      idle_inputs();
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i  = 32'h1234_5678;
      #1;
`ifdef GUVM_ARB_ROUND_ROBIN_EN
      chk("cont_rsp1_instr", bus.instr_rvalid_o, 1'b1);
      chk("cont_rsp1_data", bus.data_rvalid_o, 1'b0);
`else
      chk("cont_rsp1_instr", bus.instr_rvalid_o, 1'b0);
      chk("cont_rsp1_data", bus.data_rvalid_o, 1'b1);
`endif
      tick();
      chk("cont_rsp2_data", bus.data_rvalid_o, 1'b1);
      chk("cont_rsp2_instr", bus.instr_rvalid_o, 1'b0);
      tick();
      bus.mem_rvalid_i = 1'b0;

      // Full: two fetches accepted, third blocked until a response frees a slot
      bus.instr_req_i  = 1'b1;
      bus.instr_addr_i = 32'h0000_0400;
      bus.mem_gnt_i    = 1'b1;
      #1;
      chk("full_g1", bus.instr_gnt_o, 1'b1);
      tick();
      chk("full_g2", bus.instr_gnt_o, 1'b1);
      tick();
      chk("full_blk_req", bus.mem_req_o, 1'b0);
      chk("full_blk_gnt", bus.instr_gnt_o, 1'b0);
      tick();
      chk("full_blk2_req", bus.mem_req_o, 1'b0);
      bus.mem_rvalid_i = 1'b1;
      #1;
      chk("full_pop_req", bus.mem_req_o, 1'b0);
      chk("full_pop_rvalid", bus.instr_rvalid_o, 1'b1);
      tick();
      bus.mem_rvalid_i = 1'b0;
      bus.mem_gnt_i    = 1'b0;
      #1;
      chk("full_reassert", bus.mem_req_o, 1'b1);
      tick();
      bus.instr_req_i  = 1'b0;
      bus.mem_rvalid_i = 1'b1;
      #1;
      chk("full_drain", bus.instr_rvalid_o, 1'b1);
      tick();
      bus.mem_rvalid_i = 1'b0;

      // Lock: stalled fetch keeps the bus while data request arrives
      bus.instr_req_i  = 1'b1;
      bus.instr_addr_i = 32'h0000_0300;
      bus.mem_gnt_i    = 1'b0;
      #1;
      chk("lock_c1_addr", bus.mem_addr_o, 32'h0000_0300);
      tick();
      bus.data_req_i   = 1'b1;
      bus.data_we_i    = 1'b0;
      bus.data_be_i    = 4'h3;
      bus.data_addr_i  = 32'h0000_0010;
      #1;
      chk("lock_c2_addr", bus.mem_addr_o, 32'h0000_0300);
      chk("lock_c2_be", bus.mem_be_o, 4'hF);
      tick();
      chk("lock_c3_addr", bus.mem_addr_o, 32'h0000_0300);
      tick();
      bus.mem_gnt_i = 1'b1;
      #1;
      chk("lock_gnt_instr", bus.instr_gnt_o, 1'b1);
      chk("lock_gnt_data", bus.data_gnt_o, 1'b0);
      chk("lock_gnt_addr", bus.mem_addr_o, 32'h0000_0300);
      tick();
      chk("lock_next_data", bus.data_gnt_o, 1'b1);
      chk("lock_next_addr", bus.mem_addr_o, 32'h0000_0010);
      chk("lock_next_be", bus.mem_be_o, 4'h3);
      tick();
      idle_inputs();
      bus.mem_rvalid_i = 1'b1;
      #1;
      chk("lock_rsp1_instr", bus.instr_rvalid_o, 1'b1);
      tick();
      chk("lock_rsp2_data", bus.data_rvalid_o, 1'b1);
      chk("lock_rsp2_instr", bus.instr_rvalid_o, 1'b0);
      tick();

      // Spurious response with nothing outstanding
      chk("spur_instr_rvalid", bus.instr_rvalid_o, 1'b0);
      chk("spur_data_rvalid", bus.data_rvalid_o, 1'b0);
      chk("spur_err_before", err, 1'b0);
      tick();
      bus.mem_rvalid_i = 1'b0;
      #1;
      chk("spur_err_set", err, 1'b1);
      tick();
      chk("spur_err_sticky", err, 1'b1);
      rst = 1'b1;
      tick();
      chk("spur_err_cleared", err, 1'b0);
      rst = 1'b0;

      // Reset with two outstanding discards them; later response is spurious
      bus.instr_req_i = 1'b1;
      bus.mem_gnt_i   = 1'b1;
      #1;
      chk("rst2_g1", bus.instr_gnt_o, 1'b1);
      tick();
      chk("rst2_g2", bus.instr_gnt_o, 1'b1);
      tick();
      idle_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.instr_req_i = 1'b1;
      #1;
      chk("rst2_empty_req", bus.mem_req_o, 1'b1);
      bus.instr_req_i  = 1'b0;
      bus.mem_rvalid_i = 1'b1;
      #1;
      chk("rst2_late_rvalid", bus.instr_rvalid_o, 1'b0);
      tick();
      bus.mem_rvalid_i = 1'b0;
      #1;
      chk("rst2_late_err", err, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/guvm_mem_arbiter.md
GUVM_MEM_ARBITER -- requirements
Module: guvm_mem_arbiter

Interface
REQ-001 Parameter MAX_OUTSTANDING, default 2, maximum accepted-but-unanswered memory transactions; legal range 1..4.
REQ-002 The block SHALL use one clock, clk_i; reset is rst_i, synchronous and active-high.
REQ-003 clk_i  input  1  clock; all state updates on rising edge.
REQ-004 rst_i  input  1  synchronous active-high reset.
REQ-005 instr_req_i  input  1  instruction fetch request.
REQ-006 instr_addr_i  input  32  fetch address.
REQ-007 instr_gnt_o  output  1  fetch request accepted this cycle.
REQ-008 instr_rvalid_o  output  1  fetch response valid; data on rdata_o.
REQ-009 data_req_i  input  1  load/store request.
REQ-010 data_we_i  input  1  1 = store.
REQ-011 data_be_i  input  4  byte enables.
REQ-012 data_addr_i  input  32  load/store address.
REQ-013 data_wdata_i  input  32  store data.
REQ-014 data_gnt_o  output  1  load/store request accepted this cycle.
REQ-015 data_rvalid_o  output  1  load/store response valid.
REQ-016 rdata_o  output  32  response data, equal to mem_rdata_i.
REQ-017 mem_req_o / mem_we_o / mem_be_o / mem_addr_o / mem_wdata_o  output  1/1/4/32/32  shared memory request channel.
REQ-018 mem_gnt_i  input  1  memory accepts request.
REQ-019 mem_rvalid_i  input  1  memory response valid, in request order.
REQ-020 mem_rdata_i  input  32  memory response data.
REQ-021 err_o  output  1  sticky: mem_rvalid_i seen with no outstanding transaction.

Function
REQ-022 Handshake: transfer occurs when mem_req_o & mem_gnt_i; granted requester's gnt_o SHALL be high that cycle only, combinational from mem_gnt_i.
REQ-023 mem_req_o SHALL be (instr_req_i | data_req_i) & (count < MAX_OUTSTANDING) & !rst_i; a pop in the same cycle does not relieve a full condition.
REQ-024 Mux: data selected -> data_* fields forwarded; instr selected -> mem_we_o=0, mem_be_o=4'hF, mem_addr_o=instr_addr_i, mem_wdata_o=0.
REQ-025 Lock: if mem_req_o high and mem_gnt_i low, a lock flag SHALL set and hold the current selection until the handshake; lock clears on handshake.
REQ-026 On each handshake the requester ID (0=instr, 1=data) SHALL be pushed into an in-order ID FIFO of depth MAX_OUTSTANDING; pointers wrap modulo depth.
REQ-027 On mem_rvalid_i with count>0, head ID SHALL be popped and the matching rvalid_o asserted in the same cycle (zero latency); other rvalid_o low.
REQ-028 Push and pop in the same cycle SHALL leave count unchanged.
REQ-029 mem_rvalid_i with count==0: no rvalid_o, no pointer change, err_o set until reset.
REQ-030 Requester deasserting req without grant while unlocked: no state change; selection re-evaluated next cycle.

Reset
REQ-031 While rst_i high: mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o = 0; count, pointers, lock = 0; err_o = 0; round-robin priority = instr.
REQ-032 Reset mid-transaction SHALL discard all outstanding IDs; responses arriving after reset are treated per REQ-029.

Configuration
REQ-033 Macro GUVM_ARB_ROUND_ROBIN_EN defined: on contention the requester not granted at the last handshake wins; priority register updates only on handshake.
REQ-034 Macro undefined: fixed priority, data always wins contention; no priority register.

Verification
REQ-035 Single fetch: instr_req_i=1, addr 0x0000_0100, mem_gnt_i=1; rvalid next cycle with 0x002180B3 -> instr_gnt_o pulse, instr_rvalid_o=1, rdata_o=0x002180B3.
REQ-036 Contention: both req, store addr 0x10 data 0xDEAD_BEEF be 4'hF -> fixed: data granted first; RR (reset priority instr): instr first, then data, alternating.
REQ-037 Full: MAX_OUTSTANDING=2, three grants attempted with no rvalid -> third blocked, mem_req_o=0 until first rvalid, then reasserts next cycle.
REQ-038 Lock: instr selected, mem_gnt_i=0 for 3 cycles, data_req_i rises cycle 2 -> mem_addr_o stays instr_addr_i until grant (fixed-priority build).
REQ-039 Spurious: mem_rvalid_i=1 with empty FIFO -> no rvalid_o, err_o=1 until rst_i; reset with 2 outstanding -> count=0, later rvalid sets err_o.
